// File: rtl/delay_line_seq.sv
// Circular delay-line initiator for a single-port sample memory: writes one sample per
// frame, then streams the NTAPS newest samples (newest first). Optional masking: ZERO_FILL_EN.
module delay_line_seq #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16,
    parameter int NTAPS  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_en,
    output logic              mem_wmode,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              tap_valid,
    output logic [DATA_W-1:0] tap_data,
    output logic [ADDR_W-1:0] tap_index,
    output logic              tap_last
);

    // state   | meaning
    // S_IDLE  | waiting for a sample, memory idle
    // S_WRITE | sample written at wr_ptr
    // S_READ  | read head-k for k = 0..NTAPS-1
    // S_DRAIN | last tap presented, memory idle
    typedef enum logic [1:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN} state_t;

    localparam logic [ADDR_W-1:0] K_LAST = ADDR_W'(NTAPS - 1);

    state_t r_state;
    state_t w_state_nxt;

    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_head;
    logic [ADDR_W-1:0] r_k;
    logic [ADDR_W-1:0] r_mem_addr;
    logic              r_mem_en;
    logic              r_mem_wmode;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_tap_valid;
    logic [ADDR_W-1:0] r_tap_index;
    logic              r_tap_last;

    logic              w_accept;
    logic              w_read_done;
    logic [ADDR_W-1:0] w_mem_addr_nxt;
    logic              w_mem_en_nxt;
    logic              w_mem_wmode_nxt;
    logic [DATA_W-1:0] w_mem_wdata_nxt;
    logic [DATA_W-1:0] w_tap_src;

    assign in_ready    = (r_state == S_IDLE) & ~clear & ~reset;
    assign w_accept    = in_valid & in_ready;
    assign w_read_done = (r_state == S_READ) && (r_k == K_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = S_READ;
            S_READ:  if (w_read_done) w_state_nxt = S_DRAIN;
            S_DRAIN: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Memory controls are registered, so compute what the next cycle must present.
    always_comb begin
        w_mem_en_nxt    = 1'b0;
        w_mem_wmode_nxt = 1'b0;
        w_mem_addr_nxt  = r_mem_addr;
        w_mem_wdata_nxt = r_mem_wdata;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    w_mem_en_nxt    = 1'b1;
                    w_mem_wmode_nxt = 1'b1;
                    w_mem_addr_nxt  = r_wr_ptr;
                    w_mem_wdata_nxt = in_data;
                end
            end
            S_WRITE: begin
                w_mem_en_nxt   = 1'b1;
                w_mem_addr_nxt = r_wr_ptr;
            end
            S_READ: begin
                if (!w_read_done) begin
                    w_mem_en_nxt   = 1'b1;
                    w_mem_addr_nxt = r_head - (r_k + ADDR_W'(1));
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr    <= '0;
            r_head      <= '0;
            r_k         <= '0;
            r_mem_addr  <= '0;
            r_mem_en    <= 1'b0;
            r_mem_wmode <= 1'b0;
            r_mem_wdata <= '0;
            r_tap_valid <= 1'b0;
            r_tap_index <= '0;
            r_tap_last  <= 1'b0;
        end else begin
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_en    <= w_mem_en_nxt;
            r_mem_wmode <= w_mem_wmode_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
            if (r_state == S_IDLE && clear) begin
                r_wr_ptr <= '0;
            end else if (r_state == S_WRITE) begin
                r_head   <= r_wr_ptr;
                r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
                r_k      <= '0;
            end else if (r_state == S_READ) begin
                r_k <= r_k + ADDR_W'(1);
            end
            // Read data returns one cycle after the read edge, so tap sideband lags by one.
            r_tap_valid <= (r_state == S_READ);
            r_tap_index <= (r_state == S_READ) ? r_k : '0;
            r_tap_last  <= w_read_done;
        end
    end

`ifdef ZERO_FILL_EN
    localparam int FILL_W = ADDR_W + 1;
    logic [FILL_W-1:0] r_fill_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_fill_cnt <= '0;
        end else if (r_state == S_IDLE && clear) begin
            r_fill_cnt <= '0;
        end else if (r_state == S_WRITE && r_fill_cnt < FILL_W'(NTAPS)) begin
            r_fill_cnt <= r_fill_cnt + FILL_W'(1);
        end
    end

    assign w_tap_src = ({1'b0, r_tap_index} >= r_fill_cnt) ? '0 : mem_rdata;
`else
    assign w_tap_src = mem_rdata;
`endif

    assign mem_addr  = r_mem_addr;
    assign mem_en    = r_mem_en;
    assign mem_wmode = r_mem_wmode;
    assign mem_wdata = r_mem_wdata;
    assign tap_valid = r_tap_valid;
    assign tap_data  = r_tap_valid ? w_tap_src : '0;
    assign tap_index = r_tap_index;
    assign tap_last  = r_tap_last;

endmodule

// File: tb/tb_delay_line_seq.sv
// Scoreboard bench for delay_line_seq (NTAPS=4) with a behavioural 256x16 RW0 memory.
module tb_delay_line_seq;

    localparam int NT = 4;
`ifdef ZERO_FILL_EN
    localparam bit ZF = 1'b1;
`else
    localparam bit ZF = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        clear = 1'b0;
    logic        in_valid = 1'b0;
    logic [15:0] in_data = '0;
    logic        in_ready;
    logic [7:0]  mem_addr;
    logic        mem_en, mem_wmode;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata = '0;
    logic        tap_valid, tap_last;
    logic [15:0] tap_data;
    logic [7:0]  tap_index;

    delay_line_seq #(.ADDR_W(8), .DATA_W(16), .NTAPS(NT)) dut (
        .clk(clk), .reset(reset), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .mem_addr(mem_addr), .mem_en(mem_en), .mem_wmode(mem_wmode),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .tap_valid(tap_valid),
        .tap_data(tap_data), .tap_index(tap_index), .tap_last(tap_last)
    );

    always #5 clk = ~clk;

    // Power-up contents are a known pattern so unwritten locations are predictable.
    logic [15:0] mem [256];
    logic [15:0] ref_mem [256];
    initial for (int a = 0; a < 256; a++) begin
        mem[a] = 16'hC000 | 16'(a);
        ref_mem[a] = 16'hC000 | 16'(a);
    end
    always @(posedge clk) if (mem_en) begin
        if (mem_wmode) mem[mem_addr] <= mem_wdata;
        else           mem_rdata <= mem[mem_addr];
    end

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic flag(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s at %0t", name, $time);
    endtask

    // Scoreboard queues and reference state
    logic [23:0] exp_wr[$];
    logic [7:0]  exp_rd[$];
    logic [24:0] exp_tap[$];
    logic [7:0]  ref_wp = '0;
    int          ref_fill = 0;

    task automatic model_issue(input logic [15:0] d);
        logic [7:0]  head, a;
        logic [15:0] td;
        ref_mem[ref_wp] = d;
        exp_wr.push_back({ref_wp, d});
        head = ref_wp;
        ref_wp = ref_wp + 8'd1;
        if (ref_fill < NT) ref_fill++;
        for (int k = 0; k < NT; k++) begin
            a  = head - 8'(k);
            exp_rd.push_back(a);
            td = (ZF && k >= ref_fill) ? 16'h0000 : ref_mem[a];
            exp_tap.push_back({td, 8'(k), (k == NT - 1)});
        end
    endtask

    task automatic model_reset();
        ref_wp = '0;
        ref_fill = 0;
        exp_wr.delete();
        exp_rd.delete();
        exp_tap.delete();
    endtask

    // Per-frame logs for the hand-computed vectors
    logic [7:0]  wr_addr_log;
    logic [7:0]  rd_log [4];
    logic [15:0] tap_log [4];
    logic        last_log [4];
    int rd_n = 0, tap_n = 0;

    always @(negedge clk) if (!reset) begin
        logic [23:0] ew;
        logic [24:0] et;
        if (mem_en && mem_wmode) begin
            wr_addr_log = mem_addr;
            rd_n = 0;
            tap_n = 0;
            if (exp_wr.size() == 0) flag("unexpected write");
            else begin
                ew = exp_wr.pop_front();
                chk("write addr", {24'h0, mem_addr}, {24'h0, ew[23:16]});
                chk("write data", {16'h0, mem_wdata}, {16'h0, ew[15:0]});
            end
        end
        if (mem_en && !mem_wmode) begin
            if (rd_n < 4) rd_log[rd_n] = mem_addr;
            rd_n++;
            if (exp_rd.size() == 0) flag("unexpected read");
            else chk("read addr", {24'h0, mem_addr}, {24'h0, exp_rd.pop_front()});
        end
        if (tap_valid) begin
            if (tap_n < 4) begin
                tap_log[tap_n]  = tap_data;
                last_log[tap_n] = tap_last;
            end
            tap_n++;
            if (exp_tap.size() == 0) flag("unexpected tap");
            else begin
                et = exp_tap.pop_front();
                chk("tap data",  {16'h0, tap_data},  {16'h0, et[24:9]});
                chk("tap index", {24'h0, tap_index}, {24'h0, et[8:1]});
                chk("tap last",  {31'h0, tap_last},  {31'h0, et[0]});
            end
        end else if (tap_last) flag("tap_last without tap_valid");
    end

    task automatic send(input logic [15:0] d);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) begin
            flag("send timeout waiting for in_ready");
            return;
        end
        in_valid = 1'b1;
        in_data  = d;
        model_issue(d);
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int guard = 0;
        @(negedge clk);
        while (!(in_ready && exp_tap.size() == 0 && exp_rd.size() == 0 && exp_wr.size() == 0)
               && guard < 200) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 200) flag("wait_idle timeout");
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        reset = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state
        #3;
        chk("in_ready during reset", {31'h0, in_ready}, 0);
        chk("mem_en during reset", {31'h0, mem_en}, 0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("in_ready after reset", {31'h0, in_ready}, 1);
        chk("idle outputs", {mem_en, mem_wmode, mem_addr, mem_wdata},  '0);
        chk("idle taps", {tap_valid, tap_last, tap_index, tap_data}, '0);
        repeat (4) @(negedge clk);

        // Two frames: writes 0,1; second frame reads 1,0,255,254
        send(16'h0011);
        send(16'h0022);
        wait_idle();
        chk("frame2 write addr", {24'h0, wr_addr_log}, 32'd1);
        chk("frame2 rd0", {24'h0, rd_log[0]}, 32'd1);
        chk("frame2 rd1", {24'h0, rd_log[1]}, 32'd0);
        chk("frame2 rd2", {24'h0, rd_log[2]}, 32'd255);
        chk("frame2 rd3", {24'h0, rd_log[3]}, 32'd254);
        chk("frame2 tap0", {16'h0, tap_log[0]}, 32'h0022);
        chk("frame2 tap1", {16'h0, tap_log[1]}, 32'h0011);
        chk("frame2 tap2", {16'h0, tap_log[2]}, ZF ? 32'h0 : 32'hC0FF);
        chk("frame2 tap3", {16'h0, tap_log[3]}, ZF ? 32'h0 : 32'hC0FE);
        chk("frame2 last3", {31'h0, last_log[3]}, 1);
        chk("frame2 last0", {31'h0, last_log[0]}, 0);

        // Latency: in_valid held high across the whole frame
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 16'h0033;
        model_issue(16'h0033);
        @(posedge clk);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            chk($sformatf("lat in_ready c%0d", i), {31'h0, in_ready}, (i == 7) ? 1 : 0);
            chk($sformatf("lat write c%0d", i), {31'h0, mem_en & mem_wmode}, (i == 1) ? 1 : 0);
            chk($sformatf("lat tap_valid c%0d", i), {31'h0, tap_valid}, (i >= 3 && i <= 6) ? 1 : 0);
            chk($sformatf("lat tap_last c%0d", i), {31'h0, tap_last}, (i == 6) ? 1 : 0);
            if (i == 7) in_valid = 1'b0;
        end
        wait_idle();

        // clear beats in_valid; next sample lands at address 0
        @(negedge clk);
        clear    = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'h0BAD;
        #1 chk("in_ready with clear", {31'h0, in_ready}, 0);
        @(negedge clk);
        clear    = 1'b0;
        in_valid = 1'b0;
        ref_wp   = '0;
        ref_fill = 0;
        send(16'h0055);
        wait_idle();
        chk("clear write addr", {24'h0, wr_addr_log}, 32'd0);
        chk("clear tap0", {16'h0, tap_log[0]}, 32'h0055);
        chk("clear tap1", {16'h0, tap_log[1]}, ZF ? 32'h0 : 32'hC0FF);
        chk("clear tap2", {16'h0, tap_log[2]}, ZF ? 32'h0 : 32'hC0FE);
        chk("clear tap3", {16'h0, tap_log[3]}, ZF ? 32'h0 : 32'hC0FD);

        // Reset during the read of tap 2
        send(16'h0066);
        repeat (3) @(posedge clk);
        #2 reset = 1'b1;
        model_reset();
        #1;
        chk("abort mem_en", {31'h0, mem_en}, 0);
        chk("abort taps", {tap_valid, tap_last, tap_index, tap_data}, '0);
        chk("abort in_ready", {31'h0, in_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        send(16'h0077);
        wait_idle();
        chk("post-abort write addr", {24'h0, wr_addr_log}, 32'd0);
        chk("post-abort tap0", {16'h0, tap_log[0]}, 32'h0077);

        // Wrap: 260 back-to-back frames, data = frame number
        pulse_reset();
        for (int f = 0; f < 259; f++) send(16'(f));
        wait_idle();
        chk("wrap write addr", {24'h0, wr_addr_log}, 32'd2);
        chk("wrap rd0", {24'h0, rd_log[0]}, 32'd2);
        chk("wrap rd1", {24'h0, rd_log[1]}, 32'd1);
        chk("wrap rd2", {24'h0, rd_log[2]}, 32'd0);
        chk("wrap rd3", {24'h0, rd_log[3]}, 32'd255);
        chk("wrap tap0", {16'h0, tap_log[0]}, 32'h0102);
        chk("wrap tap1", {16'h0, tap_log[1]}, 32'h0101);
        chk("wrap tap2", {16'h0, tap_log[2]}, 32'h0100);
        chk("wrap tap3", {16'h0, tap_log[3]}, 32'h00FF);
        send(16'd259);
        wait_idle();

        chk("exp_tap drained", exp_tap.size(), 0);
        chk("exp_rd drained", exp_rd.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/delay_line_seq.md
Name: delay_line_seq

Overview:
Initiator for the 256x16 single-port audio sample memory (RW0-style port: addr, en, wmode, wdata, rdata). It accepts one stereo-channel sample per frame and writes it into a circular delay line. It then streams the NTAPS most recent samples, newest first, to the FIR MAC datapath. One instance per channel sits between the input sample interface and the MAC.

Parameters:
ADDR_W, 8, memory address width; the delay line wraps modulo 2^ADDR_W
DATA_W, 16, sample width
NTAPS, 32, taps streamed per frame; legal range 1..2^ADDR_W

Ports:
clk  input  1  clock; also drives the memory RW0_clk
reset  input  1  asynchronous, active-high reset
clear  input  1  synchronous request to empty the delay line
in_valid  input  1  new sample offered
in_data  input  DATA_W  sample value
in_ready  output  1  sample accepted when in_valid & in_ready
mem_addr  output  ADDR_W  to memory RW0_addr, registered
mem_en  output  1  to memory RW0_en, registered
mem_wmode  output  1  to memory RW0_wmode (1 = write), registered
mem_wdata  output  DATA_W  to memory RW0_wdata, registered
mem_rdata  input  DATA_W  from memory RW0_rdata; valid the cycle after a read edge
tap_valid  output  1  tap_data is valid this cycle
tap_data  output  DATA_W  delayed sample x[n-k]
tap_index  output  ADDR_W  k, counting 0..NTAPS-1
tap_last  output  1  high with tap_valid on k = NTAPS-1

Behaviour:
- Reset is asynchronous and active-high.
  - State goes to IDLE; wr_ptr = 0, fill_cnt = 0.
  - mem_en, mem_wmode, mem_addr, mem_wdata, tap_valid, tap_index, tap_last all = 0.
  - in_ready = 0 while reset is asserted; memory contents are not touched.
- in_ready = (state == IDLE) & ~clear. No other state accepts samples.
- FSM states: IDLE -> WRITE -> READ -> DRAIN -> IDLE.
- IDLE: mem_en = 0.
  - clear = 1: wr_ptr <= 0, fill_cnt <= 0, stay in IDLE; clear takes priority over in_valid.
  - Acceptance: latch in_data, go to WRITE.
  - clear outside IDLE is ignored. It is not queued.
- WRITE (1 cycle): mem_en = 1, mem_wmode = 1, mem_addr = wr_ptr, mem_wdata = latched sample.
  - head <= wr_ptr; wr_ptr <= wr_ptr + 1 (wraps).
  - fill_cnt <= min(fill_cnt + 1, NTAPS).
- READ (NTAPS cycles, k = 0..NTAPS-1): mem_en = 1, mem_wmode = 0, mem_addr = head - k modulo 2^ADDR_W.
  - Wrap-around is required: with head = 1, k = 3 gives address 254.
- DRAIN (1 cycle): mem_en = 0; the final tap is presented.
- Tap output timing:
  - tap k is valid the cycle after its read cycle, so tap 0 is valid in the first READ cycle + 1 and tap NTAPS-1 in DRAIN.
  - tap_data is mem_rdata passed through combinationally, subject to the mask below.
  - tap_index and tap_last are registered.
- No backpressure: the consumer must accept every tap.
- Latency, with the sample accepted in cycle n:
  - write in cycle n+1.
  - tap 0 in cycle n+3; tap_last in cycle n+2+NTAPS.
  - in_ready high again in cycle n+3+NTAPS.
  - Minimum frame period is NTAPS+3 cycles.
- Reset mid-frame aborts immediately: no further memory access, no tap_last. The next frame starts from wr_ptr = 0.
- NTAPS = 1: READ lasts one cycle; tap_last coincides with tap 0.

Optional Feature:
ZERO_FILL_EN
- Defined: tap_data = 0 for any k >= fill_cnt, so locations never written since reset or clear read as silence. The memory read is still issued.
- Undefined: tap_data = mem_rdata unconditionally and fill_cnt logic is removed; power-up garbage can reach the MAC until NTAPS samples have been written.

Test Plan:
- Reset release, NTAPS=4, in_valid=0 -> in_ready=1 in the cycle after reset falls, all mem_*/tap_* outputs = 0, no mem_en pulses.
- NTAPS=4, samples 0x0011, 0x0022 in successive frames -> writes to addresses 0 and 1. Frame 2 reads addresses 1,0,255,254. With ZERO_FILL_EN, taps = 0x0022, 0x0011, 0, 0 and tap_last is on index 3.
- NTAPS=4, 260 frames with data = frame number -> wr_ptr wraps 255->0. Frame with head=2 reads addresses 2,1,0,255; tap_data equals the last four samples, newest first.
- Sample accepted in cycle 10, NTAPS=4 -> write in cycle 11, taps in cycles 13-16, in_ready low in cycles 11-16 and high in cycle 17. in_valid held high in between is not accepted.
- clear and in_valid both high in IDLE -> no acceptance, fill_cnt = 0. Next sample is written at address 0; with ZERO_FILL_EN, taps 1..3 = 0.
- reset asserted during the READ of tap 2 -> outputs go to 0 immediately, no tap_last. The next frame writes address 0.
